// File: rtl/mmm_pkg.sv
// mmm_pkg: shared fetch-side types for the icache interface.
package mmm_pkg;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            err;
  } icache_out_t;
  typedef enum logic [1:0] {RESET, READY, ADDR_BUSY} ifc_state_t;
endpackage

// File: rtl/icache_ifc_cnt.sv
// icache_ifc_cnt: up/down in-flight counter with clear and load.
module icache_ifc_cnt #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc,
  input  logic         dec,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (load) cnt <= load_val;
    else cnt <= cnt + W'(inc) - W'(dec);
endmodule

// File: rtl/icache_fetch_ifc.sv
// icache_fetch_ifc: pipelined IF-to-icache adapter with in-order responses and flush-by-count.
// Optional perf counters enabled by defining ICACHE_FETCH_IFC_PERF_EN.
module icache_fetch_ifc #(
  parameter int XLEN            = mmm_pkg::XLEN,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 read_req_i,
  output logic                 req_ready_o,
  output mmm_pkg::icache_out_t cache_out_o,
  output logic                 read_done_o,
  output logic [XLEN-1:0]      addr_o,
  output logic                 addr_valid_o,
  input  logic                 addr_ready_i,
  input  mmm_pkg::icache_out_t data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o
`ifdef ICACHE_FETCH_IFC_PERF_EN
  ,
  output logic [31:0]          perf_req_o,
  output logic [31:0]          perf_stall_o
`endif
);
  import mmm_pkg::*;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  ifc_state_t state, next;
  logic [XLEN-1:0] saved_pc;
  logic busy_stale, accept, addr_hs, busy_hs, data_hs;
  logic [CW-1:0] live_cnt, drop_cnt;
  logic [CW:0] inflight;
  assign inflight = (CW+1)'(live_cnt) + (CW+1)'(drop_cnt);
  assign cache_out_o = data_i;
  always_comb begin
    req_ready_o  = state == READY && !flush_i && inflight < (CW+1)'(MAX_OUTSTANDING);
    accept       = read_req_i && req_ready_o;
    addr_valid_o = accept || state == ADDR_BUSY;
    addr_o       = state == ADDR_BUSY ? saved_pc : pc_i;
    addr_hs      = addr_valid_o && addr_ready_i;
    busy_hs      = state == ADDR_BUSY && addr_ready_i;
    data_ready_o = inflight != '0;
    data_hs      = data_valid_i && data_ready_o;
    read_done_o  = data_hs && drop_cnt == '0 && !flush_i;
    next = state == RESET ? READY :
           state == READY ? (accept && !addr_ready_i ? ADDR_BUSY : READY) :
           (addr_ready_i ? READY : ADDR_BUSY);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state      <= RESET;
      saved_pc   <= '0;
      busy_stale <= 1'b0;
    end else begin
      state      <= next;
      if (accept && !addr_ready_i) saved_pc <= pc_i;
      busy_stale <= state == ADDR_BUSY && !addr_ready_i && (busy_stale || flush_i);
    end
  // Flush folds every live request (and a flushed address completing now) into the drop count.
  icache_ifc_cnt #(.W(CW)) u_live (
    .clk_i, .rst_i,
    .inc(addr_hs && !(busy_hs && busy_stale)),
    .dec(data_hs && drop_cnt == '0),
    .clear(flush_i),
    .load(1'b0),
    .load_val('0),
    .cnt(live_cnt)
  );
  icache_ifc_cnt #(.W(CW)) u_drop (
    .clk_i, .rst_i,
    .inc(busy_hs && busy_stale),
    .dec(data_hs && drop_cnt != '0),
    .clear(1'b0),
    .load(flush_i),
    .load_val(drop_cnt + live_cnt + CW'(busy_hs) - CW'(data_hs)),
    .cnt(drop_cnt)
  );
`ifdef ICACHE_FETCH_IFC_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      perf_req_o   <= '0;
      perf_stall_o <= '0;
    end else begin
      perf_req_o   <= perf_req_o + 32'(accept && perf_req_o != '1);
      perf_stall_o <= perf_stall_o + 32'(read_req_i && !req_ready_o && perf_stall_o != '1);
    end
`endif
  assert property (@(posedge clk_i) disable iff (rst_i) data_valid_i |-> data_ready_o);
endmodule

// File: tb/tb_icache_fetch_ifc.sv
// tb_icache_fetch_ifc: table-driven cycle vectors with an in-order response scoreboard.
module tb_icache_fetch_ifc;
  import mmm_pkg::*;
  typedef struct {
    logic rst, fl, rq;
    logic [31:0] pc;
    logic ar, dv;
    logic [31:0] dat;
    logic rr, av;
    logic [31:0] addr;
    logic dr, rd;
  } vec_t;
  logic clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0, read_req_i = 1'b0;
  logic addr_ready_i = 1'b0, data_valid_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic req_ready_o, read_done_o, addr_valid_o, data_ready_o;
  logic [31:0] addr_o;
  icache_out_t cache_out_o, data_i;
`ifdef ICACHE_FETCH_IFC_PERF_EN
  logic [31:0] perf_req_o, perf_stall_o;
`endif
  int total = 0, bad = 0;
  vec_t vecs[$];
  logic [31:0] sb[$];
  icache_fetch_ifc #(.XLEN(32), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .pc_i(pc_i),
    .read_req_i(read_req_i), .req_ready_o(req_ready_o), .cache_out_o(cache_out_o),
    .read_done_o(read_done_o), .addr_o(addr_o), .addr_valid_o(addr_valid_o),
    .addr_ready_i(addr_ready_i), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o)
`ifdef ICACHE_FETCH_IFC_PERF_EN
    , .perf_req_o(perf_req_o), .perf_stall_o(perf_stall_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  initial data_i = '{data: 32'h0, err: 1'b0};

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic add(input logic rst, fl, rq, input logic [31:0] pc, input logic ar, dv,
                     input logic [31:0] dat, input logic rr, av, input logic [31:0] addr,
                     input logic dr, rd);
    vec_t v;
    v = '{rst, fl, rq, pc, ar, dv, dat, rr, av, addr, dr, rd};
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v, input int idx);
    logic [31:0] exp_d;
    @(negedge clk_i);
    rst_i = v.rst; flush_i = v.fl; read_req_i = v.rq; pc_i = v.pc;
    addr_ready_i = v.ar; data_valid_i = v.dv; data_i = '{data: v.dat, err: 1'b0};
    #2;
    chk($sformatf("req_ready[%0d]", idx), 32'(req_ready_o), 32'(v.rr));
    chk($sformatf("addr_valid[%0d]", idx), 32'(addr_valid_o), 32'(v.av));
    chk($sformatf("addr[%0d]", idx), addr_o, v.addr);
    chk($sformatf("data_ready[%0d]", idx), 32'(data_ready_o), 32'(v.dr));
    chk($sformatf("read_done[%0d]", idx), 32'(read_done_o), 32'(v.rd));
    chk($sformatf("cache_out[%0d]", idx), cache_out_o.data, v.dat);
`ifdef ICACHE_FETCH_IFC_PERF_EN
    if (v.rst) begin
      chk($sformatf("perf_req_rst[%0d]", idx), perf_req_o, 32'h0);
      chk($sformatf("perf_stall_rst[%0d]", idx), perf_stall_o, 32'h0);
    end
`endif
    if (v.rst || v.fl) sb.delete();
    if (read_done_o === 1'b1) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sb_empty[%0d]: got done with nothing pending want none", idx);
      end else begin
        exp_d = sb.pop_front();
        chk($sformatf("sb_data[%0d]", idx), cache_out_o.data, exp_d);
      end
    end
    if (v.rq && v.rr && !v.rst) sb.push_back(v.pc);
  endtask

  initial begin
    // rst, fl, rq, pc, ar, dv, dat | rr, av, addr, dr, rd
    add(1,0,1,32'h010,0,0,32'h0,   0,0,32'h010,0,0);
    add(0,0,1,32'h014,0,0,32'h0,   0,0,32'h014,0,0);
    // back-to-back with capacity stall
    add(0,0,1,32'h100,1,0,32'h0,   1,1,32'h100,0,0);
    add(0,0,1,32'h104,1,0,32'h0,   1,1,32'h104,1,0);
    add(0,0,1,32'h108,1,1,32'h100, 0,0,32'h108,1,1);
    add(0,0,1,32'h108,1,1,32'h104, 1,1,32'h108,1,1);
    add(0,0,0,32'h10c,0,1,32'h108, 1,0,32'h10c,1,1);
    add(0,0,0,32'h10c,0,0,32'h0,   1,0,32'h10c,0,0);
    // address held while icache stalls
    add(0,0,1,32'h200,0,0,32'h0,   1,1,32'h200,0,0);
    add(0,0,1,32'h204,0,0,32'h0,   0,1,32'h200,0,0);
    add(0,0,1,32'h208,0,0,32'h0,   0,1,32'h200,0,0);
    add(0,0,1,32'h20c,1,0,32'h0,   0,1,32'h200,0,0);
    add(0,0,0,32'h210,0,1,32'h200, 1,0,32'h210,1,1);
    // flush with two live
    add(0,0,1,32'h240,1,0,32'h0,   1,1,32'h240,0,0);
    add(0,0,1,32'h244,1,0,32'h0,   1,1,32'h244,1,0);
    add(0,1,1,32'h248,0,0,32'h0,   0,0,32'h248,1,0);
    add(0,0,0,32'h24c,0,1,32'h240, 0,0,32'h24c,1,0);
    add(0,0,1,32'h300,1,1,32'h244, 1,1,32'h300,1,0);
    add(0,0,0,32'h304,0,1,32'h300, 1,0,32'h304,1,1);
    // flush during ADDR_BUSY
    add(0,0,1,32'h400,0,0,32'h0,   1,1,32'h400,0,0);
    add(0,1,0,32'h404,0,0,32'h0,   0,1,32'h400,0,0);
    add(0,0,1,32'h408,0,0,32'h0,   0,1,32'h400,0,0);
    add(0,0,0,32'h40c,1,0,32'h0,   0,1,32'h400,0,0);
    add(0,0,0,32'h410,0,1,32'h400, 1,0,32'h410,1,0);
    add(0,0,0,32'h414,0,0,32'h0,   1,0,32'h414,0,0);
    // flush coinciding with data, one live
    add(0,0,1,32'h500,1,0,32'h0,   1,1,32'h500,0,0);
    add(0,1,0,32'h504,0,1,32'h500, 0,0,32'h504,1,0);
    add(0,0,0,32'h508,0,0,32'h0,   1,0,32'h508,0,0);
    foreach (vecs[i]) step(vecs[i], i);
    // reset pulse with two requests in flight
    step('{0,0,1,32'h600,1,0,32'h0,   1,1,32'h600,0,0}, 100);
    step('{0,0,1,32'h604,1,0,32'h0,   1,1,32'h604,1,0}, 101);
    step('{1,0,1,32'h608,1,0,32'h0,   0,0,32'h608,0,0}, 102);
    step('{0,0,1,32'h60c,1,0,32'h0,   0,0,32'h60c,0,0}, 103);
    step('{0,0,1,32'h610,1,0,32'h0,   1,1,32'h610,0,0}, 104);
    step('{0,0,0,32'h614,0,1,32'h610, 1,0,32'h614,1,1}, 105);
    chk("sb_drained", 32'(sb.size()), 32'h0);
`ifdef ICACHE_FETCH_IFC_PERF_EN
    chk("perf_req", perf_req_o, 32'h1);
    chk("perf_stall", perf_stall_o, 32'h1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
